dwa_element_scheduler: RTL and testbench

Data-weighted-averaging (DWA) element scheduler for the DEM-DAC. It accepts one quantizer output code per handshake and converts it into a unit-element enable pattern. It rotates a pointer so every unit DAC element is used equally over time, which first-order shapes element-mismatch error. It sits between the quantizer output (`quantized_out_o`) and the unit-element switch block.

---
 rtl/lib_switchblock_pkg.sv | 8 +
 rtl/dwa_mask_gen.sv | 19 +
 rtl/dwa_element_scheduler.sv | 63 ++++++
 tb/tb_dwa_element_scheduler.sv | 109 ++++++++++
 4 files changed

// File: rtl/lib_switchblock_pkg.sv
// lib_switchblock_pkg: shared DEM-DAC switch-block widths, element count and enums.
package lib_switchblock_pkg;
    localparam int OUTPUT_WIDTH = 3;
    localparam int NUM_ELEMENTS = 2**OUTPUT_WIDTH - 1;
    localparam int PTR_WIDTH    = $clog2(NUM_ELEMENTS);
    typedef enum logic [1:0] {DEM_DWA, DEM_STATIC, DEM_MUTE, DEM_RSVD} dem_mode_e;
    typedef enum logic {IDLE, RUN} sched_state_e;
endpackage

// File: rtl/dwa_mask_gen.sv
// dwa_mask_gen: k-ones thermometer rotated left by p (mod NUM_ELEMENTS) and wrapped next pointer.
module dwa_mask_gen #(
    parameter int OUTPUT_WIDTH = 3,
    parameter int NUM_ELEMENTS = 7,
    parameter int PTR_WIDTH    = 3
) (
    input  logic [OUTPUT_WIDTH-1:0] k,
    input  logic [PTR_WIDTH-1:0]    p,
    output logic [NUM_ELEMENTS-1:0] mask,
    output logic [PTR_WIDTH-1:0]    next_p
);
    int sum;
    assign sum    = int'(p) + int'(k);
    assign next_p = PTR_WIDTH'(sum >= NUM_ELEMENTS ? sum - NUM_ELEMENTS : sum);
    // element i is lit when its distance ahead of p is below k
    for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_el
        assign mask[i] = ((i >= int'(p)) ? i - int'(p) : i + NUM_ELEMENTS - int'(p)) < int'(k);
    end
endmodule

// File: rtl/dwa_element_scheduler.sv
// dwa_element_scheduler: turns accepted quantizer codes into rotating unit-element enables.
module dwa_element_scheduler #(
    parameter int OUTPUT_WIDTH = lib_switchblock_pkg::OUTPUT_WIDTH,
    parameter int NUM_ELEMENTS = 2**OUTPUT_WIDTH - 1,
    parameter int PTR_WIDTH    = $clog2(NUM_ELEMENTS)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [1:0]              mode_i,
    input  logic                    sync_clear_i,
    input  logic [OUTPUT_WIDTH-1:0] code_i,
    input  logic                    code_valid_i,
    output logic                    code_ready_o,
    output logic [NUM_ELEMENTS-1:0] elem_en_o,
    output logic                    elem_valid_o,
    output logic [PTR_WIDTH-1:0]    ptr_o
);
    import lib_switchblock_pkg::*;
    localparam logic [OUTPUT_WIDTH:0] n_wide = (OUTPUT_WIDTH+1)'(NUM_ELEMENTS);
    sched_state_e              state;
    dem_mode_e                 mode;
    logic                      accept;
    logic [OUTPUT_WIDTH-1:0]   code_sat;
    logic [PTR_WIDTH-1:0]      mask_p;
    logic [PTR_WIDTH-1:0]      next_p;
    logic [NUM_ELEMENTS-1:0]   mask;
    assign mode         = dem_mode_e'(mode_i);
    assign code_ready_o = (state == RUN) && enable_i;
    assign accept       = code_valid_i && code_ready_o;
    assign code_sat     = ({1'b0, code_i} > n_wide) ? OUTPUT_WIDTH'(NUM_ELEMENTS) : code_i;
    // static mode is just a rotation from element 0
    assign mask_p       = (mode == DEM_STATIC) ? '0 : ptr_o;
    dwa_mask_gen #(
        .OUTPUT_WIDTH(OUTPUT_WIDTH),
        .NUM_ELEMENTS(NUM_ELEMENTS),
        .PTR_WIDTH(PTR_WIDTH)
    ) u_mask (
        .k(code_sat),
        .p(mask_p),
        .mask(mask),
        .next_p(next_p)
    );
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            elem_en_o    <= '0;
            elem_valid_o <= 1'b0;
            ptr_o        <= '0;
        end else begin
            state        <= enable_i ? RUN : IDLE;
            elem_valid_o <= accept;
            if (accept) begin
                elem_en_o <= (mode == DEM_DWA || mode == DEM_STATIC) ? mask : '0;
                ptr_o     <= (mode == DEM_DWA) ? next_p : (mode == DEM_STATIC) ? '0 : ptr_o;
            end else if (state == RUN && !enable_i) begin
                elem_en_o <= '0;
            end
            if (sync_clear_i)
                ptr_o <= '0;
        end
    end
endmodule

// File: tb/tb_dwa_element_scheduler.sv
// tb_dwa_element_scheduler: directed checks of the DWA scheduler against hand-computed patterns.
module tb_dwa_element_scheduler;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       enable_i = 1'b0;
    logic [1:0] mode_i = 2'b00;
    logic       sync_clear_i = 1'b0;
    logic [2:0] code_i = '0;
    logic       code_valid_i = 1'b0;
    logic       code_ready_o;
    logic [6:0] elem_en_o;
    logic       elem_valid_o;
    logic [2:0] ptr_o;
    int total = 0;
    int bad = 0;

    dwa_element_scheduler dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .enable_i(enable_i),
        .mode_i(mode_i),
        .sync_clear_i(sync_clear_i),
        .code_i(code_i),
        .code_valid_i(code_valid_i),
        .code_ready_o(code_ready_o),
        .elem_en_o(elem_en_o),
        .elem_valid_o(elem_valid_o),
        .ptr_o(ptr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic out(input string tag, input logic [6:0] en, input logic [2:0] p, input logic v);
        check({tag, "_en"}, 32'(elem_en_o), 32'(en));
        check({tag, "_ptr"}, 32'(ptr_o), 32'(p));
        check({tag, "_valid"}, 32'(elem_valid_o), 32'(v));
    endtask

    initial begin
        cyc();
        cyc();
        out("reset", 7'b0000000, 3'd0, 1'b0);
        check("reset_ready", 32'(code_ready_o), 32'd0);
        rst_i = 1'b0;
        enable_i = 1'b1;
        #1 check("idle_ready", 32'(code_ready_o), 32'd0);
        cyc();
        check("run_ready", 32'(code_ready_o), 32'd1);
        code_i = 3'd3; code_valid_i = 1'b1;
        cyc(); out("dwa3a", 7'b0000111, 3'd3, 1'b1);
        cyc(); out("dwa3b", 7'b0111000, 3'd6, 1'b1);
        cyc(); out("dwa3c", 7'b1000011, 3'd2, 1'b1);
        code_valid_i = 1'b0;
        cyc(); out("hold", 7'b1000011, 3'd2, 1'b0);
        code_i = 3'd0; code_valid_i = 1'b1;
        cyc(); out("dwa0", 7'b0000000, 3'd2, 1'b1);
        code_i = 3'd7;
        cyc(); out("dwa7", 7'b1111111, 3'd2, 1'b1);
        code_i = 3'd2;
        cyc(); out("dwa2", 7'b0001100, 3'd4, 1'b1);
        mode_i = 2'b01; code_i = 3'd5;
        cyc(); out("stat5a", 7'b0011111, 3'd0, 1'b1);
        cyc(); out("stat5b", 7'b0011111, 3'd0, 1'b1);
        mode_i = 2'b00; code_i = 3'd2;
        cyc(); out("dwa2b", 7'b0000011, 3'd2, 1'b1);
        code_i = 3'd1;
        cyc(); out("dwa1", 7'b0000100, 3'd3, 1'b1);
        mode_i = 2'b10; code_i = 3'd6;
        cyc(); out("mute6", 7'b0000000, 3'd3, 1'b1);
        mode_i = 2'b00; code_i = 3'd1;
        cyc(); out("dwa1b", 7'b0001000, 3'd4, 1'b1);
        code_i = 3'd2; sync_clear_i = 1'b1;
        cyc(); out("clr_acc", 7'b0110000, 3'd0, 1'b1);
        sync_clear_i = 1'b0; code_valid_i = 1'b0; mode_i = 2'b10;
        cyc(); out("mode_noacc", 7'b0110000, 3'd0, 1'b0);
        mode_i = 2'b00; code_i = 3'd5; code_valid_i = 1'b1;
        cyc(); out("dwa5", 7'b0011111, 3'd5, 1'b1);
        code_i = 3'd3; enable_i = 1'b0;
        #1 check("drop_ready", 32'(code_ready_o), 32'd0);
        cyc(); out("drop", 7'b0000000, 3'd5, 1'b0);
        cyc(); out("idle", 7'b0000000, 3'd5, 1'b0);
        check("idle_ready2", 32'(code_ready_o), 32'd0);
        code_valid_i = 1'b0; sync_clear_i = 1'b1;
        cyc(); out("clr_idle", 7'b0000000, 3'd0, 1'b0);
        sync_clear_i = 1'b0; enable_i = 1'b1;
        cyc();
        code_valid_i = 1'b1; code_i = 3'd3;
        cyc(); out("rerun", 7'b0000111, 3'd3, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        out("async_rst", 7'b0000000, 3'd0, 1'b0);
        check("async_rst_ready", 32'(code_ready_o), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
